regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Sole owner of the register file write port (write-enable, write-register, write-data); write port registered, one-cycle latency.
- After reset, sequences a clear of every register.
- Then arbitrates the write port between the writeback stage and a debug/loader write channel.
- Starvation guard: freezes the pipeline for one cycle so a waiting debug write is always serviced.

Parameters:
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register index width
DATA_W, 32, register data width
INIT_VALUE, 0, value written to registers 1..NUM_REGS-1 during init
MAX_WAIT, 4, consecutive blocked debug cycles before the stall is forced

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; forces INIT
wbWrite  input  1  writeback stage requests a register write
wbRegister  input  ADDR_W  writeback destination register
wbData  input  DATA_W  writeback data
debugValid  input  1  debug write request valid
debugRegister  input  ADDR_W  debug destination register
debugData  input  DATA_W  debug data
debugReady  output  1  debug request accepted this cycle (combinational)
pipelineStall  output  1  freeze pipeline (combinational from state)
initDone  output  1  register file clear complete
rfWrite  output  1  register file write enable (registered)
rfWriteRegister  output  ADDR_W  register file write index (registered)
rfWriteData  output  DATA_W  register file write data (registered)

Behaviour:
- Reset (async, any time, including mid-init): state=INIT, initCounter=0, waitCount=0; rfWrite=0, rfWriteRegister=0, rfWriteData=0, initDone=0, debugReady=0, pipelineStall=1.
- INIT, each cycle:
  - Registers rfWrite=1, rfWriteRegister=initCounter, rfWriteData = (initCounter==0 ? 0 : INIT_VALUE).
  - initCounter increments; after index NUM_REGS-1 is issued, next state RUN.
  - Exactly NUM_REGS write cycles, indices 0..NUM_REGS-1 in order.
  - pipelineStall=1, debugReady=0; wbWrite and debugValid ignored.
- RUN: initDone=1. Define forceDebug = (waitCount==MAX_WAIT).
  - pipelineStall = forceDebug.
  - wbEffective = wbWrite && wbRegister!=0 && !forceDebug.
  - debugReady = !wbEffective.
  - Debug handshake = debugValid && debugReady.
  - Next write port: wbEffective -> wb register/data; else handshake -> debug register/data, with rfWrite = (debugRegister!=0); else rfWrite=0, rfWriteRegister/rfWriteData hold.
  - Writeback has priority except when forceDebug=1. A wb write dropped in a forced cycle is safe: the frozen pipeline re-presents the same write next cycle.
- waitCount:
  - Clears on handshake or debugValid=0.
  - Else increments while debugValid && !debugReady, saturating at MAX_WAIT.
  - Maximum debug latency: MAX_WAIT+1 cycles.
- Register 0:
  - wb write to 0 is discarded and does not occupy the port (debug may be granted that cycle).
  - Debug write to 0 completes the handshake but produces rfWrite=0.
- Debug fields must be stable while debugValid=1 and debugReady=0.
- Write data visible in the register file one cycle after acceptance; the register file consumes it on the following negedge.
- FSM: INIT -> RUN (after last index); any state -> INIT on reset. No other transitions.

Test Plan:
- Reset deassert, INIT_VALUE=32'hDEADBEEF -> 32 cycles rfWrite=1, indices 0..31; reg0 data 0, others DEADBEEF; then initDone=1, pipelineStall=0; file reads r0=0, r5=DEADBEEF.
- RUN, wbWrite reg 8 data 32'h12 with debugValid reg 9 data 32'h34 same cycle -> debugReady=0; reg8=0x12 next cycle; debug granted the first cycle wbWrite=0, reg9=0x34 the cycle after.
- wbWrite to reg 0 every cycle with debugValid reg 3 -> debugReady=1 immediately; reg0 stays 0; reg3 written; pipelineStall never asserted.
- wbWrite to regs 1..6 continuously with debugValid reg 10 data 7, MAX_WAIT=4 -> waitCount 1..4; cycle 5 pipelineStall=1, debugReady=1, reg10=7; waitCount=0 and stall drops next cycle.
- Assert reset at initCounter=17 -> outputs return to reset values immediately; on release init restarts at index 0, 32 full writes.
- debugValid reg 0 data 32'hFF, no wb -> handshake completes, rfWrite stays 0, r0 reads 0.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Sole owner of the register file write port. After reset it walks every
//   register index once, writing 0 to r0 and INIT_VALUE to the rest; after that
//   it arbitrates the port between the writeback stage and a debug/loader
//   channel. Writeback normally wins. A debug request that has been blocked for
//   MAX_WAIT consecutive cycles forces a one-cycle pipeline freeze so that the
//   debug write goes through.
//
// Ports
//   clk, reset                     clock (rising edge), async active-high reset
//   wbWrite/wbRegister/wbData      writeback write request
//   debugValid/debugRegister/
//   debugData                      debug write request (hold while not ready)
//   debugReady                     debug request accepted this cycle (comb)
//   pipelineStall                  freeze the pipeline (comb from state)
//   initDone                       register clear sequence finished
//   rfWrite/rfWriteRegister/
//   rfWriteData                    registered write port to the register file
module regfile_port_arbiter #(
  parameter int                NUM_REGS   = 32,
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter int                MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbWrite,
  input  logic [ADDR_W-1:0] wbRegister,
  input  logic [DATA_W-1:0] wbData,
  input  logic              debugValid,
  input  logic [ADDR_W-1:0] debugRegister,
  input  logic [DATA_W-1:0] debugData,
  output logic              debugReady,
  output logic              pipelineStall,
  output logic              initDone,
  output logic              rfWrite,
  output logic [ADDR_W-1:0] rfWriteRegister,
  output logic [DATA_W-1:0] rfWriteData
);

  localparam int                WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   init_cnt, init_cnt_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;

  logic                vld_p0;
  logic [ADDR_W-1:0]   wr_reg_p0;
  logic [DATA_W-1:0]   wr_data_p0;
  logic                vld_p1;
  logic [ADDR_W-1:0]   wr_reg_p1;
  logic [DATA_W-1:0]   wr_data_p1;

  logic                force_dbg;
  logic                wb_eff;
  logic                dbg_hs;

  // Blocked-cycle counter stops at MAX_WAIT; reaching it is what forces the stall.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + 1'b1;
  endfunction

  // Stage p0: arbitration and next write-port contents
  always_comb begin
    state_nxt     = state;
    init_cnt_nxt  = init_cnt;
    wait_cnt_nxt  = wait_cnt;
    vld_p0        = 1'b0;
    wr_reg_p0     = wr_reg_p1;
    wr_data_p0    = wr_data_p1;
    force_dbg     = 1'b0;
    wb_eff        = 1'b0;
    dbg_hs        = 1'b0;
    debugReady    = 1'b0;
    pipelineStall = 1'b1;
    initDone      = 1'b0;

    unique case (state)
      ST_INIT: begin
        vld_p0       = 1'b1;
        wr_reg_p0    = init_cnt;
        wr_data_p0   = (init_cnt == '0) ? '0 : INIT_VALUE;
        init_cnt_nxt = init_cnt + 1'b1;
        wait_cnt_nxt = '0;
        if (init_cnt == LAST_IDX) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        initDone      = 1'b1;
        force_dbg     = (wait_cnt == WAIT_MAX);
        pipelineStall = force_dbg;
        // A write to r0 is a no-op, so it never takes the port away from debug.
        // In a forced cycle the frozen pipeline re-presents the dropped wb write.
        wb_eff        = wbWrite && (wbRegister != '0) && !force_dbg;
        debugReady    = !wb_eff;
        dbg_hs        = debugValid && debugReady;

        if (wb_eff) begin
          vld_p0     = 1'b1;
          wr_reg_p0  = wbRegister;
          wr_data_p0 = wbData;
        end else if (dbg_hs) begin
          vld_p0     = (debugRegister != '0);
          wr_reg_p0  = debugRegister;
          wr_data_p0 = debugData;
        end

        if (dbg_hs || !debugValid) wait_cnt_nxt = '0;
        else                       wait_cnt_nxt = sat_inc(wait_cnt);
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Stage p1: registered write port and control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      wait_cnt   <= '0;
      vld_p1     <= 1'b0;
      wr_reg_p1  <= '0;
      wr_data_p1 <= '0;
    end else begin
      state      <= state_nxt;
      init_cnt   <= init_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      vld_p1     <= vld_p0;
      wr_reg_p1  <= wr_reg_p0;
      wr_data_p1 <= wr_data_p0;
    end
  end

  assign rfWrite         = vld_p1;
  assign rfWriteRegister = wr_reg_p1;
  assign rfWriteData     = wr_data_p1;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

  localparam int          NR = 32;
  localparam int          AW = 5;
  localparam int          DW = 32;
  localparam int          MW = 4;
  localparam logic [31:0] IV = 32'hDEADBEEF;

  logic          clk;
  logic          reset;
  logic          wbWrite;
  logic [AW-1:0] wbRegister;
  logic [DW-1:0] wbData;
  logic          debugValid;
  logic [AW-1:0] debugRegister;
  logic [DW-1:0] debugData;
  logic          debugReady;
  logic          pipelineStall;
  logic          initDone;
  logic          rfWrite;
  logic [AW-1:0] rfWriteRegister;
  logic [DW-1:0] rfWriteData;

  regfile_port_arbiter #(
    .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .INIT_VALUE(IV), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .wbWrite(wbWrite), .wbRegister(wbRegister), .wbData(wbData),
    .debugValid(debugValid), .debugRegister(debugRegister), .debugData(debugData),
    .debugReady(debugReady), .pipelineStall(pipelineStall), .initDone(initDone),
    .rfWrite(rfWrite), .rfWriteRegister(rfWriteRegister), .rfWriteData(rfWriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the DUT write port; consumes writes on the negedge.
  logic [DW-1:0] rf_tb [NR];
  always @(negedge clk) if (rfWrite) rf_tb[rfWriteRegister] <= rfWriteData;

  // Reference model
  bit            m_run;
  int            m_idx;
  int            m_wait;
  bit            e_vld;
  logic [AW-1:0] e_reg;
  logic [DW-1:0] e_data;
  logic [DW-1:0] mdl_rf [NR];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_idx = 0; m_wait = 0;
    e_vld = 0; e_reg = '0; e_data = '0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rfWrite", rfWrite, 0);
    chk("rst_rfWriteRegister", rfWriteRegister, 0);
    chk("rst_rfWriteData", rfWriteData, 0);
    chk("rst_initDone", initDone, 0);
    chk("rst_debugReady", debugReady, 0);
    chk("rst_pipelineStall", pipelineStall, 1);
  endtask

  // One clock cycle: drive inputs, check outputs against the model at the
  // negedge, advance the model, and return just after the next posedge.
  task automatic cycle(input bit wb, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                       input bit dv, input logic [AW-1:0] dr, input logic [DW-1:0] dd,
                       output bit hs, output bit stall);
    bit frc, weff, rdy;
    wbWrite = wb; wbRegister = wr; wbData = wd;
    debugValid = dv; debugRegister = dr; debugData = dd;
    @(negedge clk);
    frc   = m_run && (m_wait == MW);
    weff  = m_run && wb && (wr != 0) && !frc;
    rdy   = m_run && !weff;
    hs    = dv && rdy;
    stall = !m_run || frc;
    chk("debugReady", debugReady, rdy);
    chk("pipelineStall", pipelineStall, stall);
    chk("initDone", initDone, m_run);
    chk("rfWrite", rfWrite, e_vld);
    chk("rfWriteRegister", rfWriteRegister, e_reg);
    chk("rfWriteData", rfWriteData, e_data);
    if (!m_run) begin
      e_vld  = 1;
      e_reg  = AW'(m_idx);
      e_data = (m_idx == 0) ? '0 : IV;
      mdl_rf[m_idx] = e_data;
      m_idx++;
      if (m_idx == NR) m_run = 1;
    end else begin
      if (weff) begin
        e_vld = 1; e_reg = wr; e_data = wd;
        mdl_rf[wr] = wd;
      end else if (hs) begin
        e_vld = (dr != 0); e_reg = dr; e_data = dd;
        if (dr != 0) mdl_rf[dr] = dd;
      end else begin
        e_vld = 0;
      end
      if (hs || !dv) m_wait = 0;
      else if (m_wait < MW) m_wait++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit h, s;
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, h, s);
  endtask

  initial begin
    bit            hs, st, last_st, dv_p, wb_p, dvr;
    logic [AW-1:0] dr_p, wr_p;
    logic [DW-1:0] dd_p, wd_p;
    int            wi, guard;

    reset = 1; wbWrite = 0; wbRegister = '0; wbData = '0;
    debugValid = 0; debugRegister = '0; debugData = '0;
    for (int i = 0; i < NR; i++) mdl_rf[i] = '1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    reset = 0;

    // Clear sequence, then file contents
    idle(NR);
    idle(1);
    chk("r0_after_init", rf_tb[0], 32'h0);
    chk("r5_after_init", rf_tb[5], IV);

    // wb and debug collide: wb first, debug next free cycle
    cycle(1, 5'd8, 32'h12, 1, 5'd9, 32'h34, hs, st);
    cycle(0, '0, '0, 1, 5'd9, 32'h34, hs, st);
    idle(2);
    chk("r8_wb", rf_tb[8], 32'h12);
    chk("r9_dbg", rf_tb[9], 32'h34);

    // wb to r0 never blocks debug
    repeat (3) cycle(1, 5'd0, 32'h55, 1, 5'd3, 32'hA5, hs, st);
    idle(2);
    chk("r0_wb_discard", rf_tb[0], 32'h0);
    chk("r3_dbg", rf_tb[3], 32'hA5);

    // Starvation: continuous wb to r1..r6, debug r10 forced through
    wi = 1; dvr = 1; guard = 0;
    while (wi <= 6 && guard < 20) begin
      cycle(1, AW'(wi), 32'(100 + wi), dvr, 5'd10, 32'd7, hs, st);
      if (!st) wi++;
      if (hs) dvr = 0;
      guard++;
    end
    chk("starve_loop_bounded", guard < 20, 1);
    idle(2);
    chk("r10_forced", rf_tb[10], 32'd7);
    chk("r5_replayed", rf_tb[5], 32'd105);
    chk("r6_wb", rf_tb[6], 32'd106);

    // Debug write to r0: handshake, no write
    cycle(0, '0, '0, 1, 5'd0, 32'hFF, hs, st);
    idle(2);
    chk("r0_dbg_discard", rf_tb[0], 32'h0);

    // Reset in RUN, then again mid-init at initCounter=17
    reset = 1; #2;
    chk_reset_outputs();
    @(posedge clk); #1;
    reset = 0; model_reset();
    idle(17);
    reset = 1; #2;
    chk_reset_outputs();
    @(posedge clk); #1;
    reset = 0; model_reset();

    // Full init again with random (ignored) inputs
    for (int i = 0; i < NR; i++)
      cycle($urandom_range(0, 1), AW'($urandom), $urandom, $urandom_range(0, 1),
            AW'($urandom), $urandom, hs, st);

    // Random traffic
    dv_p = 0; last_st = 0; wb_p = 0; wr_p = '0; wd_p = '0; dr_p = '0; dd_p = '0;
    for (int i = 0; i < 500; i++) begin
      if (!last_st) begin
        wb_p = ($urandom % 10) < 7;
        wr_p = AW'($urandom);
        wd_p = $urandom;
      end
      if (!dv_p && ($urandom % 3) == 0) begin
        dv_p = 1;
        dr_p = (($urandom % 8) == 0) ? '0 : AW'($urandom);
        dd_p = $urandom;
      end
      cycle(wb_p, wr_p, wd_p, dv_p, dr_p, dd_p, hs, st);
      last_st = st;
      if (hs) dv_p = 0;
    end
    idle(3);
    for (int i = 0; i < NR; i++) chk($sformatf("rf[%0d]", i), rf_tb[i], mdl_rf[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
